// File: rtl/normalize_shift_iter_pkg.sv
// Shared definitions for the iterative normalizer and the rounding-stage control.
package normalize_shift_iter_pkg;

  localparam int DATA_WIDTH_DEF  = 32;
  localparam int COUNT_WIDTH_DEF = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // The stage ladder 2**(COUNT_WIDTH-1) .. 1 only covers the word when it is a power of two.
  function automatic bit widths_ok(input int data_width, input int count_width);
    return data_width == (1 << count_width);
  endfunction

endpackage

// File: rtl/normalize_shift_iter_if.sv
// Operand/result handshake bundle for the iterative normalizer.
interface normalize_shift_iter_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 5
);

  logic                   in_valid;
  logic                   in_ready;
  logic [DATA_WIDTH-1:0]  in_sig;
  logic                   in_sticky;
  logic                   out_valid;
  logic                   out_ready;
  logic [DATA_WIDTH-1:0]  out_sig;
  logic [COUNT_WIDTH-1:0] out_count;
  logic                   out_zero;
  logic                   out_sticky;

  modport master (
    output in_valid, in_sig, in_sticky, out_ready,
    input  in_ready, out_valid, out_sig, out_count, out_zero, out_sticky
  );

  modport slave (
    input  in_valid, in_sig, in_sticky, out_ready,
    output in_ready, out_valid, out_sig, out_count, out_zero, out_sticky
  );

endinterface

// File: rtl/normalize_shift_iter_stage.sv
// One logarithmic normalize step: shift left by SHIFT_BITS when the top SHIFT_BITS bits are all zero.
module normalize_shift_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int SHIFT_BITS = 1
) (
  input  logic [DATA_WIDTH-1:0] sig_i,
  output logic [DATA_WIDTH-1:0] sig_o,
  output logic                  shifted_o
);

  always_comb begin
    shifted_o = (sig_i[DATA_WIDTH-1 -: SHIFT_BITS] == '0);
    sig_o     = shifted_o ? (sig_i << SHIFT_BITS) : sig_i;
  end

endmodule

// File: rtl/normalize_shift_iter.sv
// Iterative left-normalizer: one logarithmic stage per clock, reports the total shift count.
module normalize_shift_iter
  import normalize_shift_iter_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int COUNT_WIDTH = COUNT_WIDTH_DEF
) (
  input  logic clock,
  input  logic reset,
  normalize_shift_iter_if.slave bus
);

  localparam int K_WIDTH = (COUNT_WIDTH > 1) ? $clog2(COUNT_WIDTH) : 1;

  if (!widths_ok(DATA_WIDTH, COUNT_WIDTH)) begin : g_bad_widths
    $fatal(1, "normalize_shift_iter: DATA_WIDTH must equal 2**COUNT_WIDTH");
  end

  state_t                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  sig_q, sig_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [K_WIDTH-1:0]     k_q, k_d;
  logic                   zero_q, zero_d;
  logic                   sticky_q, sticky_d;
  logic                   in_ready_c;

  logic [COUNT_WIDTH-1:0][DATA_WIDTH-1:0] stage_sig;
  logic [COUNT_WIDTH-1:0]                 stage_shifted;

  for (genvar g = 0; g < COUNT_WIDTH; g++) begin : g_stage
    normalize_shift_stage #(
      .DATA_WIDTH (DATA_WIDTH),
      .SHIFT_BITS (1 << g)
    ) u_stage (
      .sig_i     (sig_q),
      .sig_o     (stage_sig[g]),
      .shifted_o (stage_shifted[g])
    );
  end

  // DONE accepts a new operand on the same edge the result leaves (bypass accept).
  always_comb begin
    state_d    = state_q;
    sig_d      = sig_q;
    count_d    = count_q;
    k_d        = k_q;
    zero_d     = zero_q;
    sticky_d   = sticky_q;
    in_ready_c = 1'b0;

    case (state_q)
      IDLE: in_ready_c = 1'b1;
      SHIFT: begin
        if (stage_shifted[k_q]) begin
          sig_d        = stage_sig[k_q];
          count_d[k_q] = 1'b1;
        end
        if (k_q == '0) state_d = DONE;
        else           k_d     = k_q - K_WIDTH'(1);
      end
      DONE: begin
        in_ready_c = bus.out_ready;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (bus.in_valid && in_ready_c) begin
      sig_d    = bus.in_sig;
      sticky_d = bus.in_sticky;
      zero_d   = (bus.in_sig == '0);
      count_d  = '0;
      k_d      = K_WIDTH'(COUNT_WIDTH - 1);
      state_d  = SHIFT;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      sig_q    <= '0;
      count_q  <= '0;
      k_q      <= '0;
      zero_q   <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sig_q    <= sig_d;
      count_q  <= count_d;
      k_q      <= k_d;
      zero_q   <= zero_d;
      sticky_q <= sticky_d;
    end
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.out_valid  = (state_q == DONE);
  assign bus.out_sig    = sig_q;
  assign bus.out_count  = count_q;
  assign bus.out_zero   = zero_q;
  assign bus.out_sticky = sticky_q;

endmodule

// File: doc/normalize_shift_iter.md
# normalize_shift_iter

Iterative left-normalizer for the hardfloat datapath. It accepts an unnormalized significand and shifts it left, one logarithmic stage per clock, until the leading one sits in the MSB. It reports the total shift count so the exponent path can subtract it. It sits ahead of the programmable-position rounding stages (the opposite direction to the right-shift/round logic) and trades latency for area against a single-cycle normalizer.

## Interface
- `DATA_WIDTH`, 32, significand width; must equal 2**COUNT_WIDTH
- `COUNT_WIDTH`, 5, shift-count width and number of shift stages
- `clock`  in  1  sole clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state immediately
- `in_valid`  in  1  operand offered
- `in_ready`  out  1  block can accept operand this cycle
- `in_sig`  in  DATA_WIDTH  unnormalized significand
- `in_sticky`  in  1  sticky bit accompanying operand, passed through
- `out_valid`  out  1  result available
- `out_ready`  in  1  consumer accepts result
- `out_sig`  out  DATA_WIDTH  normalized significand (MSB = 1 unless zero)
- `out_count`  out  COUNT_WIDTH  left-shift amount applied
- `out_zero`  out  1  operand was all zeros
- `out_sticky`  out  1  latched in_sticky

## Operation
- States: IDLE, SHIFT, DONE. Registers: sig, count, stage index k, zero flag, sticky.
- IDLE: in_ready=1. On in_valid && in_ready:
  - latch sig=in_sig, sticky=in_sticky, zero=(in_sig==0), count=0, k=COUNT_WIDTH-1
  - go to SHIFT
- SHIFT: in_ready=0. Each cycle, with S=2**k:
  - if sig[DATA_WIDTH-1 -: S]==0, then sig <= sig<<S (zero fill) and count[k] <= 1
  - otherwise sig and count[k] are unchanged
  - if k==0, go to DONE; else k <= k-1
- DONE: out_valid=1; out_* are driven from the registers and held stable while out_ready=0.
  - in_ready = out_ready (bypass accept).
  - On out_ready: if in_valid, perform the IDLE accept and go to SHIFT; else go to IDLE.
- Zero operand: every stage shifts. Result is out_sig=0, out_count=DATA_WIDTH-1, out_zero=1.
- Bits shifted in are zeros. The sticky bit is never modified.
- in_sig/in_sticky are sampled only on the accept edge; changes on them at other times have no effect.

## Timing
- Reset values: state=IDLE, out_valid=0, out_sig=0, out_count=0, out_zero=0, out_sticky=0.
- in_ready=1 in IDLE and follows out_ready in DONE, so in_ready=1 from the first cycle after reset deassertion.
- Latency: out_valid rises exactly COUNT_WIDTH clocks after the accept edge (5 for the default parameters).
- Throughput:
  - one result per COUNT_WIDTH+1 cycles with continuous out_ready and in_valid (bypass accept)
  - COUNT_WIDTH+2 cycles when the block passes through IDLE
- Backpressure: the block stays in DONE indefinitely and the outputs do not change.
- Reset asserted in SHIFT or DONE aborts the operation; the result is discarded and never presented.
- in_valid while in SHIFT is ignored and not queued; the producer must hold it until in_ready.

## Structure
- Shared package/include: state encoding localparams (IDLE, SHIFT, DONE) and the DATA_WIDTH/COUNT_WIDTH consistency check. These are shared with the rounding stages' control.
- Sub-module `normalize_shift_stage`: combinational, parameterized by DATA_WIDTH and SHIFT_BITS; outputs the shifted significand and a "shifted" flag.
  - Instantiated COUNT_WIDTH times via generate (SHIFT_BITS=2**k).
  - The instance outputs are muxed by k into the sig/count registers.
- Top level holds the FSM, registers and handshake only.

## Test plan
- in_sig=0x00001234, in_sticky=1, out_ready=1 -> after 5 clocks: out_sig=0x91A00000, out_count=19, out_zero=0, out_sticky=1.
- in_sig=0x80000000 -> out_sig=0x80000000, out_count=0; in_sig=0x00000001 -> out_sig=0x80000000, out_count=31.
- in_sig=0 -> out_sig=0, out_count=31, out_zero=1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> outputs stable and in_ready=0. Then raise out_ready with in_valid=1 and in_sig=0x00010000 -> same-edge accept, next result out_count=15, out_sig=0x80000000.
- Assert reset during the third SHIFT cycle of in_sig=0x00000F00 -> out_valid stays 0 and all outputs return to reset values. A new operand 0x40000000 gives out_count=1 with no residue from the aborted operation.
- Random 10k operands with random in_valid/out_ready stalls against a reference leading-zero count -> every result matches and none is dropped or duplicated.
